counter_ctrl: RTL
=================

// Module: counter_ctrl
// PURPOSE
//   Sequencer for the counter datapath. Accepts a start request, arms (clears) the
//   counter, then enables it until a programmed terminal count is reached.
//   Supports one-shot and auto-reload modes, with an abort input and status outputs.
//   Sits between the control logic and the counter: it drives enable/clear and
//   mirrors the count value.
// PARAMETERS
//   WIDTH   4   width of count / limit (2..16)
//   WRAPW   8   width of the auto-reload wrap counter (saturating)
// PORTS
//   clock     in   1      system clock, rising edge
//   clear     in   1      synchronous reset, active high
//   start     in   1      request a run; sampled only in IDLE
//   stop      in   1      abort the current run; honoured in ARM and RUN
//   mode      in   1      0 = one-shot, 1 = auto-reload; latched at start
//   limit     in   WIDTH  terminal count; latched at start
//   cnt_en    out  1      counter enable; 1 only in RUN
//   cnt_clr   out  1      counter clear; 1 only in ARM
//   count     out  WIDTH  current count value (registered)
//   tc        out  1      terminal count: RUN && count == limit_q
//   busy      out  1      1 in ARM or RUN
//   done      out  1      one-cycle pulse; 1 only in DONE
//   err       out  1      one-cycle pulse: start was seen with limit == 0
//   wraps     out  WRAPW  auto-reload wraps since the last accepted start; saturates at all-ones
//   state     out  2      FSM state, for debug
// BEHAVIOUR
//   Reset: clear=1 at a rising edge forces the following on that edge.
//     - state=IDLE(00); count, limit_q, mode_q, wraps and err all go to 0.
//     - clear has priority over every other input, in every state.
//   FSM state encoding: IDLE=00, ARM=01, RUN=10, DONE=11.
//   IDLE:
//     - start=1 and limit!=0 -> ARM. On that edge: limit_q<=limit, mode_q<=mode,
//       count<=0, wraps<=0.
//     - start=1 and limit==0 -> stay in IDLE; err=1 for the next cycle only.
//     - stop is ignored in IDLE.
//   ARM: lasts exactly one cycle; cnt_clr=1, count=0.
//     - stop=1 -> IDLE. Otherwise -> RUN.
//   RUN: cnt_en=1; tc is combinational from the registered count and limit_q.
//     - Priority order: stop, then tc, then increment.
//     - stop=1 -> IDLE; count holds its value; no done pulse.
//     - tc=1, mode_q=0 -> DONE; count holds at limit_q.
//     - tc=1, mode_q=1 -> stay in RUN; count<=0; wraps<=wraps+1, saturating.
//     - Otherwise count<=count+1.
//   DONE: lasts one cycle; done=1; then -> IDLE; count holds.
//   start outside IDLE is ignored (no queueing); inputs sampled in DONE are ignored.
//   Timing for a one-shot run with limit L, start sampled at edge E0:
//     - ARM in cycle E0..E1; RUN for L+1 cycles (count 0..L).
//     - tc high in the last RUN cycle; done high in the cycle after edge E0+L+2.
//   Arithmetic:
//     - count never exceeds limit_q, so the counter never wraps past 2^WIDTH-1.
//     - limit=2^WIDTH-1 is legal.
//   Returning to IDLE leaves count and wraps readable until the next accepted start.
// TESTING
//   T1 one-shot: limit=3, mode=0, pulse start. Required:
//      busy 1 cycle later; count 0,1,2,3 in RUN; tc with count=3; done 1 cycle
//      later; IDLE next.
//   T2 auto-reload: limit=2, mode=1, run 10 RUN cycles. Required:
//      count 0,1,2,0,1,2...; tc every 3rd cycle; wraps=3; done never asserted.
//   T3 abort: limit=7, stop at count=4. Required:
//      IDLE next cycle; count holds 4; no done; cnt_en=0.
//      Repeat with stop in ARM: IDLE, count=0.
//   T4 zero limit / busy start: start with limit=0 -> err pulse, stays IDLE,
//      busy=0. start during RUN -> ignored, limit_q unchanged.
//   T5 reset mid-run: clear=1 at count=5, mode=1, wraps=2. Required on the next
//      cycle: state=00, count=0, wraps=0, all pulses low. If clear and start are
//      asserted together, clear wins.
//   T6 saturation: WRAPW=2, limit=1, mode=1, 12 RUN cycles. Required: wraps
//      sticks at 3; limit=15 (WIDTH=4) one-shot -> count reaches 15, no overflow.

Source files
------------

// File: rtl/counter_ctrl.sv
// Run sequencer for the counter datapath: arms (clears) the counter, enables it up to a
// latched terminal count, and supports one-shot, auto-reload and abort.
module counter_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WRAPW = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WRAPW-1:0] wraps,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic [WRAPW-1:0] wraps_q;
    logic [WRAPW-1:0] wraps_d;
    logic             err_q;
    logic             tc_c;

    // Terminal count is decoded from registered state only, so it is glitch-free per cycle.
    assign tc_c = (state_q == RUN) && (count_q == limit_q);

    // Increment and saturating-wrap values for the RUN datapath.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        wraps_d = wraps_q;
        if (wraps_q != {WRAPW{1'b1}}) begin
            wraps_d = wraps_q + WRAPW'(1);
        end
    end

    // Control FSM and datapath registers; clear overrides every state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            wraps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (limit != '0) begin
                            state_q <= ARM;
                            limit_q <= limit;
                            mode_q  <= mode;
                            count_q <= '0;
                            wraps_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    state_q <= stop ? IDLE : RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (tc_c) begin
                        if (mode_q) begin
                            count_q <= '0;
                            wraps_q <= wraps_d;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        count_q <= count_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cnt_en  = (state_q == RUN);
    assign cnt_clr = (state_q == ARM);
    assign busy    = (state_q == ARM) || (state_q == RUN);
    assign done    = (state_q == DONE);
    assign tc      = tc_c;
    assign err     = err_q;
    assign count   = count_q;
    assign wraps   = wraps_q;
    assign state   = state_q;

endmodule
